// File: rtl/mult_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// mult_arbiter_ctrl
//
// Sequencing controller and two-client round-robin arbiter for a shared
// WIDTH-bit shift-add signed multiplier datapath (X/A/B registers,
// adder/subtractor, operand mux). The granted client keeps the datapath for
// one full multiply. The controller drives these controls, in order:
//   - one clear/load cycle;
//   - WIDTH add/subtract + shift iterations;
//   - a one-cycle Done pulse while the product sits in A:B.
// A single iteration counter replaces unrolled per-bit states.
//
// Ports
//   Clk        in   1  system clock, rising edge
//   Reset_n    in   1  asynchronous active-low reset
//   Req        in   2  level request per client, held until that client's Done
//   M          in   1  current LSB of datapath B register
//   Grant      out  2  one-hot grant, held for the whole transaction
//   Sel        out  1  operand mux select = index of granted client
//   Clr_Ld     out  1  clear X/A and load B from selected operand
//   Add        out  1  A <= A + S (sign-extended into X)
//   Sub        out  1  A <= A - S (sign-extended into X)
//   Shift_XAB  out  1  arithmetic right shift of X:A:B
//   Done       out  2  one-cycle pulse to the granted client
//   Busy       out  1  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module mult_arbiter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] Req,
    input  logic       M,
    output logic [1:0] Grant,
    output logic       Sel,
    output logic       Clr_Ld,
    output logic       Add,
    output logic       Sub,
    output logic       Shift_XAB,
    output logic [1:0] Done,
    output logic       Busy
);

    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_last;       // index of the client served most recently
    logic          w_last_nxt;
    logic [1:0]    r_grant;
    logic [1:0]    w_grant_nxt;
    logic          r_sel;
    logic          w_sel_nxt;
    logic          w_winner;
    logic          w_last_iter;

    assign w_last_iter = (r_cnt == LAST_ITER);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that were present before the clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;     // client 0 wins the first contention
            r_grant <= 2'b00;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // NOTE: every signal written here gets a default before the case
    // statement; a path that skips an assignment would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_winner    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (Req != 2'b00) begin
                    // Under contention, serve the client that was not served last.
                    w_winner    = (Req == 2'b11) ? ~r_last : Req[1];
                    w_sel_nxt   = w_winner;
                    w_grant_nxt = w_winner ? 2'b10 : 2'b01;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last_iter) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_state_nxt = S_ADD;
                end
            end
            S_DONE: begin
                w_last_nxt  = r_sel;
                w_grant_nxt = 2'b00;
                w_sel_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 2'b00;
                w_sel_nxt   = 1'b0;
            end
        endcase
    end

    // The final iteration handles the sign bit of the multiplier. That bit
    // carries negative weight, so it subtracts instead of adding.
    assign Add       = (r_state == S_ADD) && !w_last_iter && M;
    assign Sub       = (r_state == S_ADD) &&  w_last_iter && M;

    assign Grant     = r_grant;
    assign Sel       = r_sel;
    assign Clr_Ld    = (r_state == S_LOAD);
    assign Shift_XAB = (r_state == S_SHIFT);
    assign Done      = (r_state == S_DONE) ? r_grant : 2'b00;
    assign Busy      = (r_state != S_IDLE);

endmodule
